muldiv_unit: RTL

Multi-cycle multiply/divide unit in the execute stage. It executes the ops the decoder tags `ALU_MUL_DIV` (`Mult`, `Multu`, `Div`, `Divu`) and owns the architectural HI/LO registers that `Mfhi`/`Mflo` read. Multiplies finish in one cycle. Divides are iterative, and the unit raises a busy flag so the pipeline control can stall issue.

---
 rtl/muldiv_unit_pkg.sv | 24 ++
 rtl/muldiv_unit_div_core.sv | 48 ++++
 rtl/muldiv_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, reset level, divide length and FSM encodings for the mul/div unit.
package muldiv_unit_pkg;

    localparam int ALUOpWidth = 5;
    localparam logic RstEnable = 1'b1;

    localparam logic [ALUOpWidth-1:0] Mult  = 5'd24;
    localparam logic [ALUOpWidth-1:0] Multu = 5'd25;
    localparam logic [ALUOpWidth-1:0] Div   = 5'd26;
    localparam logic [ALUOpWidth-1:0] Divu  = 5'd27;

    localparam int DivCycles = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DIV_RUN = 2'b01,
        DIV_FIX = 2'b10
    } mdState_t;

    function automatic logic isMulDiv(input logic [ALUOpWidth-1:0] op);
        return (op == Mult) || (op == Multu) || (op == Div) || (op == Divu);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Unsigned restoring divider, one quotient bit per step; the quotient register doubles as
// the dividend shift register. Caller sequences start/step/abort and owns sign handling.
module div_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         step,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    logic [W-1:0] divisorReg;
    logic [W:0]   partial;
    logic [W:0]   diff;

    // remainder < divisor always, so the shifted partial fits in W+1 bits
    assign partial = {remainder, quotient[W-1]};
    assign diff    = partial - {1'b0, divisorReg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient   <= '0;
            remainder  <= '0;
            divisorReg <= '0;
        end else if (abort) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            quotient   <= dividend;
            remainder  <= '0;
            divisorReg <= divisor;
        end else if (step) begin
            if (!diff[W]) begin
                remainder <= diff[W-1:0];
                quotient  <= {quotient[W-2:0], 1'b1};
            end else begin
                remainder <= partial[W-1:0];
                quotient  <= {quotient[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO owner: single-cycle multiply, 33-cycle iterative divide with sign fix-up.
// Ops offered while busy are dropped; upstream stalls on busy_o.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid_i,
    input  logic [ALUOpWidth-1:0] op_i,
    input  logic [DATA_W-1:0]     src_a_i,
    input  logic [DATA_W-1:0]     src_b_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o
);

    localparam int CntW = $clog2(DivCycles);

    mdState_t          state, stateNext;
    logic [CntW-1:0]   count;
    logic              qNeg, rNeg;
    logic [DATA_W-1:0] hiReg, loReg, hiNext, loNext;
    logic              wrEn, doneReg, divStep;

    logic                  accept, isDiv, isSignedDiv, divZero, startDiv;
    logic [DATA_W-1:0]     magA, magB, quo, rem;
    logic [2*DATA_W-1:0]   extA, extB, product;

    assign accept      = op_valid_i && (state == IDLE) && !flush_i && isMulDiv(op_i);
    assign isDiv       = (op_i == Div) || (op_i == Divu);
    assign isSignedDiv = (op_i == Div);
    assign divZero     = (src_b_i == '0);
    assign startDiv    = accept && isDiv && !divZero;

    assign magA = (isSignedDiv && src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
    assign magB = (isSignedDiv && src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;

    // Low 2W bits of the extended product are the same for signed and unsigned
    assign extA    = (op_i == Mult) ? {{DATA_W{src_a_i[DATA_W-1]}}, src_a_i} : {{DATA_W{1'b0}}, src_a_i};
    assign extB    = (op_i == Mult) ? {{DATA_W{src_b_i[DATA_W-1]}}, src_b_i} : {{DATA_W{1'b0}}, src_b_i};
    assign product = extA * extB;

    div_core #(.W(DATA_W)) uDivCore (
        .clk       (clk),
        .rst       (rst),
        .start     (startDiv),
        .step      (divStep),
        .abort     (flush_i && (state != IDLE)),
        .dividend  (magA),
        .divisor   (magB),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        stateNext = state;
        wrEn      = 1'b0;
        hiNext    = hiReg;
        loNext    = loReg;
        divStep   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!isDiv) begin
                        wrEn             = 1'b1;
                        {hiNext, loNext} = product;
                    end else if (divZero) begin
                        wrEn   = 1'b1;
                        hiNext = src_a_i;
                        loNext = '1;
                    end else begin
                        stateNext = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                if (flush_i) begin
                    stateNext = IDLE;
                end else begin
                    divStep = 1'b1;
                    if (count == CntW'(DivCycles - 1)) stateNext = DIV_FIX;
                end
            end
            DIV_FIX: begin
                stateNext = IDLE;
                if (!flush_i) begin
                    wrEn   = 1'b1;
                    loNext = qNeg ? -quo : quo;
                    hiNext = rNeg ? -rem : rem;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state   <= IDLE;
            count   <= '0;
            qNeg    <= 1'b0;
            rNeg    <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
            doneReg <= 1'b0;
        end else begin
            state   <= stateNext;
            doneReg <= wrEn;
            if (startDiv) begin
                count <= '0;
                qNeg  <= isSignedDiv && (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
                rNeg  <= isSignedDiv && src_a_i[DATA_W-1];
            end else if (divStep) begin
                count <= count + 1'b1;
            end
            if (wrEn) begin
                hiReg <= hiNext;
                loReg <= loNext;
            end
        end
    end

    assign busy_o = (state != IDLE);
    assign done_o = doneReg;
    assign hi_o   = hiReg;
    assign lo_o   = loReg;

endmodule
